// File: rtl/chip8_pkg.sv
// CHIP-8 shared constants and fetch-stage state encoding.
// Imported by the fetch stage and its peers.
package chip8_pkg;

  localparam int ADDR_W_DFLT = 12;
  localparam int PC_W_DFLT   = 16;

  localparam int          MEM_BYTES  = 4096;
  localparam logic [11:0] PROG_START = 12'h200;
  localparam logic [11:0] FONT_BASE  = 12'h000;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ_HI  = 3'd1;
  localparam logic [2:0] S_REQ_LO  = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_VALID   = 3'd4;

endpackage

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: two byte reads over req/gnt,
// big-endian opcode assembly, valid/ready to the core.
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int PC_W   = PC_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic              flush,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr,
  output logic [PC_W-1:0]   instr_pc,
  output logic              busy,
  output logic              addr_fault
);

  logic [2:0]      state_q;
  logic [PC_W-1:0] pc_q;
  logic [7:0]      hi_q;
  logic            hi_cap_q;
  logic [15:0]     instr_q;
  logic [PC_W-1:0] instr_pc_q;
  logic            fault_q;

  logic pc_bad;
  logic can_start;

  // The all-ones address would need pc+1 to wrap, so it faults.
  assign pc_bad = (fetch_pc[PC_W-1:ADDR_W] != '0)
                | (&fetch_pc[ADDR_W-1:0]);

  assign can_start = (state_q == S_IDLE)
                   | ((state_q == S_VALID) & instr_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      hi_q       <= '0;
      hi_cap_q   <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
      end else if (can_start && fetch_start) begin
        if (pc_bad) begin
          fault_q <= 1'b1;
          state_q <= S_IDLE;
        end else begin
          pc_q     <= fetch_pc;
          hi_cap_q <= 1'b0;
          state_q  <= S_REQ_HI;
        end
      end else begin
        case (state_q)
          S_REQ_HI: begin
            if (mem_gnt) begin
              hi_cap_q <= 1'b0;
              state_q  <= S_REQ_LO;
            end
          end
          S_REQ_LO: begin
            if (!hi_cap_q) begin
              hi_q     <= mem_rdata;
              hi_cap_q <= 1'b1;
            end
            if (mem_gnt) state_q <= S_WAIT_LO;
          end
          S_WAIT_LO: begin
            instr_q    <= {hi_q, mem_rdata};
            instr_pc_q <= pc_q;
            state_q    <= S_VALID;
          end
          S_VALID: begin
            if (instr_ready) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    case (state_q)
      S_REQ_HI: begin
        mem_req  = 1'b1;
        mem_addr = pc_q[ADDR_W-1:0];
      end
      S_REQ_LO: begin
        mem_req  = 1'b1;
        mem_addr = pc_q[ADDR_W-1:0] + ADDR_W'(1);
      end
      default: begin
        mem_req  = 1'b0;
        mem_addr = '0;
      end
    endcase
  end

  assign instr_valid = (state_q == S_VALID);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign busy        = (state_q != S_IDLE);
  assign addr_fault  = fault_q;

endmodule

// File: tb/tb_chip8_fetch.sv
// Self-checking bench for chip8_fetch: directed scenarios
// plus randomized fetches against a byte-array memory model.
module tb_chip8_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic [15:0] fetch_pc;
  logic        flush;
  logic        mem_req;
  logic        mem_gnt;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        busy;
  logic        addr_fault;

  logic [7:0] mem [0:4095];
  int n_run  = 0;
  int n_fail = 0;

  chip8_fetch dut (
    .clk(clk), .rst(rst),
    .fetch_start(fetch_start), .fetch_pc(fetch_pc),
    .flush(flush),
    .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .busy(busy), .addr_fault(addr_fault)
  );

  always #5 clk = ~clk;

  // Garbage on the bus whenever no read was issued last cycle.
  always @(posedge clk) begin
    if (mem_req && mem_gnt) mem_rdata <= mem[mem_addr];
    else mem_rdata <= 8'($urandom);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] pc);
    fetch_pc = pc;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_run++;
    if ({mem_req, instr_valid, busy, addr_fault} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=0000",
        {mem_req, instr_valid, busy, addr_fault});
    end
    n_run++;
    if ({instr, instr_pc, mem_addr} !== 44'h0) begin
      n_fail++;
      $display("FAIL reset_data got=%h/%h/%h want=0",
        instr, instr_pc, mem_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    mem[12'h200] = 8'h6A;
    mem[12'h201] = 8'h05;
    mem_gnt = 1'b1;
    instr_ready = 1'b0;
    launch(16'h0200);
    for (int c = 1; c <= 3; c++) begin
      n_run++;
      if (instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_early_valid cyc=%0d got=%b want=0",
          c, instr_valid);
      end
      tick();
    end
    n_run++;
    if (instr_valid !== 1'b1 || instr !== 16'h6A05
        || instr_pc !== 16'h0200) begin
      n_fail++;
      $display("FAIL basic_instr got=%b/%h/%h want=1/6a05/0200",
        instr_valid, instr, instr_pc);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_run++;
    if (busy !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle got busy=%b valid=%b want 0/0",
        busy, instr_valid);
    end
  endtask

  task automatic test_gnt_stall;
    int g;
    g = 0;
    mem_gnt = 1'b0;
    launch(16'h0200);
    for (int c = 1; c <= 8; c++) begin
      mem_gnt = (c == 4) || (c >= 7);
      n_run++;
      if (mem_req !== (g < 2) || instr_valid !== 1'b0
          || (g < 2 && mem_addr !== 12'h200 + 12'(g))) begin
        n_fail++;
        $display("FAIL stall_bus cyc=%0d got=%b/%h/%b want=%b/%h/0",
          c, mem_req, mem_addr, instr_valid, g < 2,
          12'h200 + 12'(g));
      end
      if (mem_gnt && g < 2) g++;
      tick();
    end
    n_run++;
    if (instr_valid !== 1'b1 || instr !== 16'h6A05) begin
      n_fail++;
      $display("FAIL stall_instr got=%b/%h want=1/6a05",
        instr_valid, instr);
    end
    mem_gnt = 1'b1;
  endtask

  task automatic test_ready_stall;
    instr_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      fetch_pc = 16'h0300;
      fetch_start = c[0];
      n_run++;
      if (instr_valid !== 1'b1 || mem_req !== 1'b0
          || instr !== 16'h6A05 || instr_pc !== 16'h0200) begin
        n_fail++;
        $display("FAIL ready_hold cyc=%0d got=%b/%b/%h/%h",
          c, instr_valid, mem_req, instr, instr_pc);
      end
      tick();
    end
    fetch_start = 1'b0;
    n_run++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0200) begin
      n_fail++;
      $display("FAIL ready_hold_end got=%b/%h want=1/0200",
        instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_run++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_release got busy=%b want 0", busy);
    end
  endtask

  task automatic test_fault;
    logic [15:0] bad [2];
    bad[0] = 16'h0FFF;
    bad[1] = 16'h1200;
    for (int i = 0; i < 2; i++) begin
      launch(bad[i]);
      n_run++;
      if (addr_fault !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_pulse pc=%h got=%b/%b/%b want=1/0/0",
          bad[i], addr_fault, busy, mem_req);
      end
      tick();
      n_run++;
      if (addr_fault !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_clear pc=%h got=%b/%b/%b want=0/0/0",
          bad[i], addr_fault, busy, mem_req);
      end
    end
  endtask

  task automatic test_flush;
    mem[12'h400] = 8'h99;
    mem[12'h401] = 8'h88;
    mem[12'h300] = 8'h12;
    mem[12'h301] = 8'h34;
    mem_gnt = 1'b1;
    launch(16'h0400);
    mem_gnt = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    fetch_start = 1'b1;
    fetch_pc = 16'h0300;
    tick();
    flush = 1'b0;
    fetch_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_run++;
      if (busy !== 1'b0 || instr_valid !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_idle cyc=%0d got=%b/%b/%b want=0/0/0",
          c, busy, instr_valid, mem_req);
      end
      tick();
    end
    mem_gnt = 1'b1;
    launch(16'h0300);
    tick();
    tick();
    tick();
    n_run++;
    if (instr_valid !== 1'b1 || instr !== 16'h1234) begin
      n_fail++;
      $display("FAIL flush_refetch got=%b/%h want=1/1234",
        instr_valid, instr);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    mem[12'h202] = 8'hA2;
    mem[12'h203] = 8'h2A;
    mem_gnt = 1'b1;
    launch(16'h0200);
    tick();
    tick();
    tick();
    instr_ready = 1'b1;
    launch(16'h0202);
    instr_ready = 1'b0;
    n_run++;
    if (busy !== 1'b1 || instr_valid !== 1'b0
        || mem_req !== 1'b1 || mem_addr !== 12'h202) begin
      n_fail++;
      $display("FAIL b2b_req got=%b/%b/%b/%h want=1/0/1/202",
        busy, instr_valid, mem_req, mem_addr);
    end
    tick();
    tick();
    tick();
    n_run++;
    if (instr_valid !== 1'b1 || instr !== 16'hA22A
        || instr_pc !== 16'h0202) begin
      n_fail++;
      $display("FAIL b2b_instr got=%b/%h/%h want=1/a22a/0202",
        instr_valid, instr, instr_pc);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    launch(16'h0300);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_run++;
    if ({mem_req, instr_valid, busy, addr_fault} !== 4'b0
        || {instr, instr_pc, mem_addr} !== 44'h0) begin
      n_fail++;
      $display("FAIL midfetch_reset got=%b %h/%h/%h want=0",
        {mem_req, instr_valid, busy, addr_fault},
        instr, instr_pc, mem_addr);
    end
  endtask

  task automatic test_random;
    logic [15:0] pc;
    logic [15:0] exp;
    int g;
    int c;
    int sel;
    int wait_n;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) pc = 16'h0FFF;
      else if (sel == 1) pc = 16'h1000 | 16'($urandom);
      else pc = 16'($urandom_range(0, 4094));
      mem_gnt = 1'($urandom);
      launch(pc);
      if (pc > 16'h0FFE) begin
        n_run++;
        if (addr_fault !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_fault pc=%h got=%b/%b want=1/0",
            pc, addr_fault, busy);
        end
        tick();
        continue;
      end
      exp = {mem[pc[11:0]], mem[pc[11:0] + 12'd1]};
      g = 0;
      c = 0;
      while (g < 2 && c < 200) begin
        mem_gnt = ($urandom_range(0, 2) != 0);
        n_run++;
        if (mem_req !== 1'b1 || instr_valid !== 1'b0
            || mem_addr !== pc[11:0] + 12'(g)) begin
          n_fail++;
          $display("FAIL rnd_bus pc=%h g=%0d got=%b/%b/%h want=1/0/%h",
            pc, g, mem_req, instr_valid, mem_addr, pc[11:0] + 12'(g));
        end
        if (mem_gnt) g++;
        c++;
        tick();
      end
      n_run++;
      if (g < 2 || mem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_wait pc=%h got g=%0d %b/%b want 2/0/0",
          pc, g, mem_req, instr_valid);
      end
      tick();
      wait_n = $urandom_range(0, 3);
      for (int w = 0; w <= wait_n; w++) begin
        n_run++;
        if (instr_valid !== 1'b1 || instr !== exp || instr_pc !== pc) begin
          n_fail++;
          $display("FAIL rnd_instr pc=%h got=%b/%h/%h want=1/%h/%h",
            pc, instr_valid, instr, instr_pc, exp, pc);
        end
        instr_ready = (w == wait_n);
        tick();
      end
      instr_ready = 1'b0;
      n_run++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_idle pc=%h got busy=%b want 0", pc, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    fetch_start = 1'b0;
    fetch_pc = '0;
    flush = 1'b0;
    mem_gnt = 1'b0;
    instr_ready = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    test_reset();
    test_basic();
    test_gnt_stall();
    test_ready_stall();
    test_fault();
    test_flush();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
